// File: rtl/key_debounce_multi_if.sv
// key_debounce_multi_if: raw key pins in, debounced levels and event pulses out
interface key_debounce_multi_if #(parameter int NUM_KEYS = 4);
  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_long;
  logic [NUM_KEYS-1:0] key_repeat;
  logic                any_press;
  modport master (output key_in, input key_level, key_press, key_release, key_long, key_repeat, any_press);
  modport slave  (input key_in, output key_level, key_press, key_release, key_long, key_repeat, any_press);
endinterface

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: per-channel synchroniser + debounce FSM with press/release/long/repeat pulses
module key_debounce_multi #(
  parameter int NUM_KEYS     = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 75_000_000,
  parameter int REPEAT_CYC   = 10_000_000,
  parameter int REPEAT_EN    = 1
) (
  input logic clk,
  input logic rst,
  key_debounce_multi_if.slave kb
);
  localparam int MX = DEBOUNCE_CYC > LONG_CYC ? (DEBOUNCE_CYC > REPEAT_CYC ? DEBOUNCE_CYC : REPEAT_CYC)
                                              : (LONG_CYC > REPEAT_CYC ? LONG_CYC : REPEAT_CYC);
  localparam int W = MX > 1 ? $clog2(MX) : 1;
  localparam logic [W-1:0] DL = W'(DEBOUNCE_CYC - 1);
  localparam logic [W-1:0] LL = W'(LONG_CYC - 1);
  localparam logic [W-1:0] RL = W'(REPEAT_CYC - 1);
  localparam logic [NUM_KEYS-1:0] IDLE_PIN = ACTIVE_LOW != 0 ? '1 : '0;
  typedef enum logic [2:0] {IDLE, PRESS_CHK, HELD, REPEAT, REL_CHK} state_t;
  state_t st [NUM_KEYS];
  logic [W-1:0] dcnt [NUM_KEYS];
  logic [W-1:0] hcnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] s1, s2, from_rep, lvl, prs, rel, lng, rpt, pr;
  assign pr = s2 ^ IDLE_PIN;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= IDLE_PIN;
      s2 <= IDLE_PIN;
      from_rep <= '0;
      lvl <= '0;
      prs <= '0;
      rel <= '0;
      lng <= '0;
      rpt <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        st[i] <= IDLE;
        dcnt[i] <= '0;
        hcnt[i] <= '0;
      end
    end else begin
      s1 <= kb.key_in;
      s2 <= s1;
      prs <= '0;
      rel <= '0;
      lng <= '0;
      rpt <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        case (st[i])
          IDLE: if (pr[i]) begin
            st[i] <= PRESS_CHK;
            dcnt[i] <= '0;
          end
          PRESS_CHK: if (!pr[i]) st[i] <= IDLE;
            else if (dcnt[i] == DL) begin
              st[i] <= HELD;
              prs[i] <= 1'b1;
              lvl[i] <= 1'b1;
              hcnt[i] <= '0;
            end else dcnt[i] <= dcnt[i] + 1'b1;
          HELD, REPEAT: if (!pr[i]) begin
              st[i] <= REL_CHK;
              from_rep[i] <= st[i] == REPEAT;
              dcnt[i] <= '0;
            end else if (st[i] == HELD && hcnt[i] == LL) begin
              st[i] <= REPEAT;
              lng[i] <= 1'b1;
              hcnt[i] <= '0;
            end else if (st[i] == REPEAT && hcnt[i] == RL) begin
              hcnt[i] <= '0;
              rpt[i] <= REPEAT_EN != 0;
            end else hcnt[i] <= hcnt[i] + 1'b1;
          REL_CHK: if (pr[i]) st[i] <= from_rep[i] ? REPEAT : HELD;
            else if (dcnt[i] == DL) begin
              st[i] <= IDLE;
              rel[i] <= 1'b1;
              lvl[i] <= 1'b0;
            end else dcnt[i] <= dcnt[i] + 1'b1;
          default: st[i] <= IDLE;
        endcase
      end
    end
  end
  assign kb.key_level = lvl;
  assign kb.key_press = prs;
  assign kb.key_release = rel;
  assign kb.key_long = lng;
  assign kb.key_repeat = rpt;
  assign kb.any_press = |prs;
endmodule

// File: tb/tb_key_debounce_multi.sv
// tb_key_debounce_multi: run-length reference model plus directed and random key stimulus
module tb_key_debounce_multi;
  localparam int N = 4, D = 8, L = 40, R = 10;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  key_debounce_multi_if #(.NUM_KEYS(N)) kb ();
  key_debounce_multi #(.NUM_KEYS(N), .ACTIVE_LOW(1), .DEBOUNCE_CYC(D), .LONG_CYC(L),
                       .REPEAT_CYC(R), .REPEAT_EN(1)) dut (.clk(clk), .rst(rst), .kb(kb.slave));
  int checks = 0, failures = 0;
  bit live = 1'b0;
  logic [N-1:0] m1, m2, prevp, e_lvl, e_prs, e_rel, e_lng, e_rpt;
  int run [N];
  int cnt [N];
  task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask
  // Level flips after D+1 consecutive samples disagreeing with it; hold time counts
  // only edges whose current and previous samples are both pressed.
  always @(posedge clk) begin
    logic [N-1:0] p;
    if (rst) begin
      m1 = '0; m2 = '0; prevp = '0;
      e_lvl = '0; e_prs = '0; e_rel = '0; e_lng = '0; e_rpt = '0;
      for (int i = 0; i < N; i++) begin run[i] = 0; cnt[i] = 0; end
      live = 1'b1;
    end else begin
      p = m2; m2 = m1; m1 = ~kb.key_in;
      e_prs = '0; e_rel = '0; e_lng = '0; e_rpt = '0;
      for (int i = 0; i < N; i++) begin
        run[i] = (p[i] != e_lvl[i]) ? run[i] + 1 : 0;
        if (run[i] == D + 1) begin
          run[i] = 0;
          cnt[i] = 0;
          if (e_lvl[i]) e_rel[i] = 1'b1; else e_prs[i] = 1'b1;
          e_lvl[i] = ~e_lvl[i];
        end else if (e_lvl[i] && p[i] && prevp[i]) begin
          cnt[i]++;
          if (cnt[i] == L) e_lng[i] = 1'b1;
          else if (cnt[i] > L && (cnt[i] - L) % R == 0) e_rpt[i] = 1'b1;
        end
        prevp[i] = p[i];
      end
    end
  end
  always @(negedge clk) if (live) begin
    chk("level", kb.key_level, e_lvl);
    chk("press", kb.key_press, e_prs);
    chk("release", kb.key_release, e_rel);
    chk("long", kb.key_long, e_lng);
    chk("repeat", kb.key_repeat, e_rpt);
    chk("any_press", {{(N-1){1'b0}}, kb.any_press}, {{(N-1){1'b0}}, |e_prs});
  end
  int tmr [N];
  logic [N-1:0] k;
  initial begin
    kb.key_in = '1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // clean press, long, repeat, release on key 0
    kb.key_in = 4'b1110;
    repeat (10) @(negedge clk);
    chk("t1_press_early", kb.key_press, 4'b0000);
    @(negedge clk);
    chk("t1_press", kb.key_press, 4'b0001);
    chk("t1_level", kb.key_level, 4'b0001);
    chk("t1_any", {3'b0, kb.any_press}, 4'b0001);
    repeat (40) @(negedge clk);
    chk("t3_long", kb.key_long, 4'b0001);
    repeat (10) @(negedge clk);
    chk("t3_repeat", kb.key_repeat, 4'b0001);
    kb.key_in = 4'b1111;
    repeat (11) @(negedge clk);
    chk("t3_release", kb.key_release, 4'b0001);
    chk("t3_level_low", kb.key_level, 4'b0000);
    // bounce on key 1
    for (int j = 0; j < 10; j++) begin
      kb.key_in[1] = ~kb.key_in[1];
      repeat (3) @(negedge clk);
    end
    kb.key_in[1] = 1'b1;
    repeat (20) @(negedge clk);
    chk("t2_level", kb.key_level, 4'b0000);
    // release glitch while held on key 0
    kb.key_in[0] = 1'b0;
    repeat (20) @(negedge clk);
    kb.key_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    kb.key_in[0] = 1'b0;
    repeat (60) @(negedge clk);
    kb.key_in = '1;
    repeat (30) @(negedge clk);
    // simultaneous press
    kb.key_in = 4'b0000;
    repeat (10) @(negedge clk);
    chk("t5_press_early", kb.key_press, 4'b0000);
    @(negedge clk);
    chk("t5_press", kb.key_press, 4'b1111);
    chk("t5_any", {3'b0, kb.any_press}, 4'b0001);
    repeat (5) @(negedge clk);
    kb.key_in = '1;
    repeat (30) @(negedge clk);
    // reset mid-hold on key 3
    kb.key_in = 4'b0111;
    repeat (15) @(negedge clk);
    chk("t6_level", kb.key_level, 4'b1000);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_level", kb.key_level, 4'b0000);
    chk("t6_rst_release", kb.key_release, 4'b0000);
    chk("t6_rst_press", kb.key_press, 4'b0000);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("t6_repress_early", kb.key_press, 4'b0000);
    @(negedge clk);
    chk("t6_repress", kb.key_press, 4'b1000);
    kb.key_in = '1;
    repeat (20) @(negedge clk);
    // random holds and bounces on all channels
    k = '1;
    for (int i = 0; i < N; i++) tmr[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (tmr[i] == 0) begin
          k[i] = 1'($urandom_range(0, 1));
          tmr[i] = ($urandom % 4 == 0) ? $urandom_range(40, 90) : $urandom_range(1, 12);
        end else tmr[i]--;
      end
      kb.key_in = k;
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
